sensor_cmd_scheduler: RTL and testbench
=======================================

Name: sensor_cmd_scheduler

Overview:
- Sequences measurement requests to the two shared sensor engines: the DHT11 reader and the SR04 ultrasonic ranger.
- Requests come from UART command bytes and from an optional periodic auto-poll tick.
- Keeps one pending request per sensor, grants one sensor at a time with round-robin, enforces a minimum re-trigger gap per sensor, and times out hung transactions.
- Sits between the UART RX path and the sensor controllers. It replaces the direct byte-to-pulse decode.

Parameters:
- DHT_GAP_CYC, 200_000_000: minimum cycles from DHT completion or timeout to its next start (2 s at 100 MHz).
- SR04_GAP_CYC, 6_000_000: minimum cycles between SR04 starts after completion or timeout (60 ms).
- TIMEOUT_CYC, 5_000_000: maximum cycles in WAIT before abort (50 ms).
- AUTO_PERIOD_CYC, 100_000_000: auto-poll tick period in cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sel  in  1  command enable; rx bytes are ignored when 0
- rx_data  in  8  UART received byte
- rx_done  in  1  1-cycle strobe, rx_data valid
- dht_done  in  1  1-cycle pulse, DHT transaction finished
- sr04_done  in  1  1-cycle pulse, SR04 transaction finished
- dht_start  out  1  1-cycle start pulse to DHT engine
- sr04_start  out  1  1-cycle start pulse to SR04 engine
- busy  out  1  high in ISSUE or WAIT
- active_sensor  out  2  01 = DHT, 10 = SR04, 00 = none
- auto_en  out  1  auto-poll mode enabled
- req_dropped  out  1  1-cycle pulse, request merged into an already-pending one
- timeout  out  1  1-cycle pulse, WAIT aborted

Behaviour:
- Reset (rst = 0, asynchronous): all outputs are 0. State IDLE, pend_dht = pend_sr04 = 0, both gap counters 0, timeout and auto counters 0, last_grant = SR04 (so DHT wins first tie).
- Commands are decoded only when rx_done && sel:
  - 0x55 'U': set pend_dht.
  - 0x44 'D': set pend_sr04.
  - 0x41 'A': auto_en <= 1 and the auto counter clears.
  - 0x53 'S': auto_en <= 0 and the auto counter clears. In-flight and pending work is kept.
  - Any other byte is ignored.
- Auto-poll: while auto_en is 1, the counter counts 0..AUTO_PERIOD_CYC-1. On wrap it sets both pend flags.
- Pending rules:
  - A request for a sensor whose pend flag is already 1 raises req_dropped for 1 cycle; the flag stays 1.
  - UART and auto-tick requests for the same sensor in the same cycle merge into one. That merge alone does not raise req_dropped.
  - The pend flag clears on entry to ISSUE. A request arriving during ISSUE or WAIT is therefore queued, not dropped.
- Gap counters: each loads its GAP_CYC on the cycle its sensor's transaction ends (done or timeout), then decrements to 0. A sensor is eligible when pend = 1 and its gap counter = 0.
- FSM:
  - IDLE: if no sensor is eligible, stay. If exactly one is eligible, grant it. If both are eligible, grant the one that is not last_grant. On grant, update last_grant and go to ISSUE.
  - ISSUE (1 cycle): assert the granted sensor's start output; busy = 1; active_sensor = grant. Clear the timeout counter, go to WAIT.
  - WAIT: increment the timeout counter and watch only the granted sensor's done input.
    - done = 1: load that sensor's gap counter and go to IDLE.
    - Counter reaches TIMEOUT_CYC-1 without done: pulse timeout, load the gap counter, go to IDLE.
    - If done and the timeout arrive in the same cycle, done wins and timeout is not pulsed.
- done pulses from the non-granted sensor, or done pulses arriving in IDLE, are ignored.
- Latency: rx_done in cycle 0 (gap 0, FSM in IDLE) → pend set in cycle 1 → start asserted in cycle 2 → WAIT from cycle 3. Done in cycle k → IDLE at k+1, with the gap counter = GAP_CYC at k+1.
- Outputs are registered. busy and active_sensor return to 0 in IDLE.
- Reset asserted mid-WAIT forces IDLE immediately, with all state cleared. No start is issued until rst = 1 and a new request arrives.

Test Plan:
All tests use DHT_GAP_CYC = 20, SR04_GAP_CYC = 10, TIMEOUT_CYC = 50, AUTO_PERIOD_CYC = 200.
1. sel = 1, byte 0x55 in cycle 0; dht_done in cycle 8 → dht_start high in cycle 2 only; busy high cycles 2-8; active_sensor = 01.
2. A second 0x55 arrives in cycle 9 → no start until the gap expires: dht_start lands 20 cycles after the gap load, not in cycle 11.
3. 0x55 and 0x44 within the same cycle window while idle → DHT starts first. After dht_done, SR04 starts 2 cycles later (no gap on SR04). Grants alternate on repeated ties.
4. Send 0x44 with sel = 0 → no sr04_start. Send 0x44 three times while the SR04 transaction is in WAIT → one queued request plus req_dropped pulsed twice.
5. 0x55, then no dht_done → timeout pulses 50 cycles after WAIT entry; state IDLE; the next 0x55 is held 20 cycles.
6. Send 0x41 → starts every 200 cycles, alternating sensors per tick as arbitrated. Then 0x53 → no further ticks. rst pulled low mid-WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/sensor_cmd_scheduler.sv
// Measurement request scheduler for the shared DHT11 and SR04 engines.
// One pending request per sensor, round-robin grant, per-sensor re-trigger gap, and a WAIT watchdog.
module sensor_cmd_scheduler #(
  parameter int unsigned DHT_GAP_CYC     = 200_000_000,
  parameter int unsigned SR04_GAP_CYC    = 6_000_000,
  parameter int unsigned TIMEOUT_CYC     = 5_000_000,
  parameter int unsigned AUTO_PERIOD_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       dht_done,
  input  logic       sr04_done,
  output logic       dht_start,
  output logic       sr04_start,
  output logic       busy,
  output logic [1:0] active_sensor,
  output logic       auto_en,
  output logic       req_dropped,
  output logic       timeout
);

  localparam int unsigned GAP_MAX = (DHT_GAP_CYC > SR04_GAP_CYC) ? DHT_GAP_CYC : SR04_GAP_CYC;
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(AUTO_PERIOD_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e        state_reg, state_next;
  logic          grant_reg, grant_next;            // 0 = DHT, 1 = SR04
  logic          last_grant_reg, last_grant_next;
  logic [1:0]    pend_reg, pend_next;
  logic [1:0]    req, eligible, gap_load;
  logic          granted, timeout_next, grant_done;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [AW-1:0] auto_cnt_reg, auto_cnt_next;
  logic          auto_en_next, tick;
  logic          cmd_valid, cmd_u, cmd_d, cmd_a, cmd_s;

  assign cmd_valid = rx_done && sel;
  assign cmd_u     = cmd_valid && (rx_data == 8'h55);
  assign cmd_d     = cmd_valid && (rx_data == 8'h44);
  assign cmd_a     = cmd_valid && (rx_data == 8'h41);
  assign cmd_s     = cmd_valid && (rx_data == 8'h53);

  assign tick       = auto_en && (auto_cnt_reg == AW'(AUTO_PERIOD_CYC - 1));
  // A UART byte and an auto tick in the same cycle collapse into a single request bit.
  assign req        = {cmd_d || tick, cmd_u || tick};
  assign grant_done = grant_reg ? sr04_done : dht_done;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sensor
      localparam logic [GW-1:0] GAP_LOAD = (gi == 0) ? GW'(DHT_GAP_CYC) : GW'(SR04_GAP_CYC);
      logic [GW-1:0] gap_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          gap_reg <= '0;
        end else if (gap_load[gi]) begin
          gap_reg <= GAP_LOAD;
        end else if (gap_reg != '0) begin
          gap_reg <= gap_reg - GW'(1);
        end
      end

      assign eligible[gi] = pend_reg[gi] && (gap_reg == '0);
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    gap_load        = 2'b00;
    timeout_next    = 1'b0;
    granted         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          granted         = 1'b1;
          grant_next      = (&eligible) ? ~last_grant_reg : eligible[1];
          last_grant_next = grant_next;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        tmo_cnt_next = '0;
        state_next   = WAIT;
      end
      WAIT: begin
        // done has priority over a coincident timeout
        if (grant_done) begin
          gap_load[grant_reg] = 1'b1;
          state_next          = IDLE;
        end else if (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          gap_load[grant_reg] = 1'b1;
          timeout_next        = 1'b1;
          state_next          = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    pend_next = pend_reg | req;
    if (granted) begin
      pend_next[grant_next] = 1'b0;
    end

    auto_en_next  = auto_en;
    auto_cnt_next = auto_cnt_reg;
    if (cmd_a || cmd_s) begin
      auto_en_next  = cmd_a;
      auto_cnt_next = '0;
    end else if (auto_en) begin
      auto_cnt_next = tick ? '0 : auto_cnt_reg + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      pend_reg       <= 2'b00;
      tmo_cnt_reg    <= '0;
      auto_cnt_reg   <= '0;
      auto_en        <= 1'b0;
      dht_start      <= 1'b0;
      sr04_start     <= 1'b0;
      busy           <= 1'b0;
      active_sensor  <= 2'b00;
      req_dropped    <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      pend_reg       <= pend_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      auto_cnt_reg   <= auto_cnt_next;
      auto_en        <= auto_en_next;
      dht_start      <= (state_next == ISSUE) && !grant_next;
      sr04_start     <= (state_next == ISSUE) && grant_next;
      busy           <= (state_next != IDLE);
      active_sensor  <= (state_next == IDLE) ? 2'b00 : (grant_next ? 2'b10 : 2'b01);
      req_dropped    <= |(req & pend_reg);
      timeout        <= timeout_next;
    end
  end

endmodule

// File: tb/tb_sensor_cmd_scheduler.sv
// Bench for sensor_cmd_scheduler: directed scenarios plus random traffic checked against
// a timestamp-based behavioural model of the scheduler.
module tb_sensor_cmd_scheduler;

  localparam int DG = 20, SG = 10, TO = 50, AP = 200;

  logic       clk = 1'b0, rst = 1'b0;
  logic       sel = 1'b0, rx_done = 1'b0, dht_done = 1'b0, sr04_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       dht_start, sr04_start, busy, auto_en, req_dropped, timeout;
  logic [1:0] active_sensor;

  sensor_cmd_scheduler #(
    .DHT_GAP_CYC(DG), .SR04_GAP_CYC(SG), .TIMEOUT_CYC(TO), .AUTO_PERIOD_CYC(AP)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .rx_data(rx_data), .rx_done(rx_done),
    .dht_done(dht_done), .sr04_done(sr04_done), .dht_start(dht_start),
    .sr04_start(sr04_start), .busy(busy), .active_sensor(active_sensor),
    .auto_en(auto_en), .req_dropped(req_dropped), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: absolute cycle stamps instead of down-counters.
  bit     m_pend [2];
  longint m_ready [2];
  int     m_last, m_phase, m_cur;           // phase 0 idle, 1 issue, 2 wait
  longint m_wait_since, m_auto_base, cyc;
  bit     m_auto;
  logic   e_dstart, e_sstart, e_busy, e_auto, e_drop, e_tmo;
  logic [1:0] e_act;
  int     resp_delay;                        // -1: engine never answers
  int     n_dstart, n_sstart, n_drop, n_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0; m_ready[0] = 0; m_ready[1] = 0;
    m_last = 1; m_phase = 0; m_cur = 0; m_auto = 0; m_auto_base = 0; m_wait_since = 0;
    e_dstart = 0; e_sstart = 0; e_busy = 0; e_auto = 0; e_drop = 0; e_tmo = 0; e_act = 2'b00;
  endtask

  task automatic model(input bit s, input bit rd, input logic [7:0] d, input bit dd, input bit sd);
    bit tick, el0, el1, g_any, done_g;
    bit [1:0] rq;
    int g;
    tick  = m_auto && ((cyc - m_auto_base) % AP == AP - 1);
    rq[0] = (rd && s && d == 8'h55) || tick;
    rq[1] = (rd && s && d == 8'h44) || tick;
    e_drop = (rq[0] && m_pend[0]) || (rq[1] && m_pend[1]);
    if (rd && s && d == 8'h41) begin
      m_auto = 1; m_auto_base = cyc + 1;
    end else if (rd && s && d == 8'h53) begin
      m_auto = 0;
    end
    e_tmo = 0; g_any = 0; g = 0;
    if (m_phase == 0) begin
      el0 = m_pend[0] && cyc >= m_ready[0];
      el1 = m_pend[1] && cyc >= m_ready[1];
      if (el0 && el1) begin g_any = 1; g = (m_last == 0) ? 1 : 0; end
      else if (el0) begin g_any = 1; g = 0; end
      else if (el1) begin g_any = 1; g = 1; end
      if (g_any) begin m_phase = 1; m_cur = g; m_last = g; end
    end else if (m_phase == 1) begin
      m_phase = 2; m_wait_since = cyc + 1;
    end else begin
      done_g = (m_cur == 0) ? dd : sd;
      if (done_g || (cyc - m_wait_since == TO - 1)) begin
        e_tmo = !done_g;
        m_phase = 0;
        m_ready[m_cur] = cyc + 1 + ((m_cur == 0) ? DG : SG);
      end
    end
    for (int k = 0; k < 2; k++) m_pend[k] = (g_any && g == k) ? 1'b0 : (m_pend[k] || rq[k]);
    e_dstart = (m_phase == 1) && (m_cur == 0);
    e_sstart = (m_phase == 1) && (m_cur == 1);
    e_busy   = (m_phase != 0);
    e_act    = e_busy ? ((m_cur == 0) ? 2'b01 : 2'b10) : 2'b00;
    e_auto   = m_auto;
  endtask

  task automatic step(input bit s, input bit rd, input logic [7:0] d, input bit dd, input bit sd);
    sel = s; rx_done = rd; rx_data = d; dht_done = dd; sr04_done = sd;
    model(s, rd, d, dd, sd);
    @(posedge clk); #1;
    cyc++;
    check("dht_start", 32'(dht_start), 32'(e_dstart));
    check("sr04_start", 32'(sr04_start), 32'(e_sstart));
    check("busy", 32'(busy), 32'(e_busy));
    check("active_sensor", 32'(active_sensor), 32'(e_act));
    check("auto_en", 32'(auto_en), 32'(e_auto));
    check("req_dropped", 32'(req_dropped), 32'(e_drop));
    check("timeout", 32'(timeout), 32'(e_tmo));
    if (dht_start === 1'b1) begin n_dstart++; $display("cycle %0d: dht start", cyc); end
    if (sr04_start === 1'b1) begin n_sstart++; $display("cycle %0d: sr04 start", cyc); end
    if (timeout === 1'b1) begin n_tmo++; $display("cycle %0d: timeout", cyc); end
    if (req_dropped === 1'b1) n_drop++;
  endtask

  // The engine model answers the granted sensor resp_delay cycles into WAIT.
  task automatic step_auto(input bit s, input bit rd, input logic [7:0] d, input bit spur_d, input bit spur_s);
    bit answer;
    answer = (resp_delay >= 0) && (m_phase == 2) && (cyc - m_wait_since >= resp_delay);
    step(s, rd, d, (answer && m_cur == 0) || spur_d, (answer && m_cur == 1) || spur_s);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_auto(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first, d0, s0;
    logic [7:0] b;
    int r;
    n_dstart = 0; n_sstart = 0; n_drop = 0; n_tmo = 0; cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_active", 32'(active_sensor), 32'd0);
    check("rst_start", 32'({dht_start, sr04_start}), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single DHT read, done in cycle 8
    resp_delay = -1;
    step_auto(1, 1, 8'h55, 0, 0);
    run(1);
    check("t1_start", 32'(dht_start), 32'd1);
    check("t1_active", 32'(active_sensor), 32'd1);
    run(6);
    check("t1_busy8", 32'(busy), 32'd1);
    step(1, 0, 8'h00, 1, 0);
    check("t1_busy9", 32'(busy), 32'd0);

    // Second read held off by the DHT gap
    resp_delay = 3;
    step_auto(1, 1, 8'h55, 0, 0);
    first = -1;
    for (int i = 0; i < 40; i++) begin
      run(1);
      if (dht_start === 1'b1 && first < 0) first = int'(cyc);
    end
    check("t2_start_cycle", 32'(first), 32'd30);

    // Back-to-back requests for both sensors
    run(30);
    d0 = n_dstart; s0 = n_sstart;
    step_auto(1, 1, 8'h55, 0, 0);
    step_auto(1, 1, 8'h44, 0, 0);
    for (int i = 0; i < 10 && busy !== 1'b1; i++) run(1);
    check("t3_first_active", 32'(active_sensor), 32'd1);
    run(40);
    check("t3_dht_starts", 32'(n_dstart - d0), 32'd1);
    check("t3_sr04_starts", 32'(n_sstart - s0), 32'd1);

    // sel gating, then drops while SR04 is in WAIT
    s0 = n_sstart;
    step_auto(0, 1, 8'h44, 0, 0);
    run(20);
    check("t4_sel0", 32'(n_sstart - s0), 32'd0);
    resp_delay = -1;
    step_auto(1, 1, 8'h44, 0, 0);
    run(4);
    n_drop = 0;
    repeat (3) step_auto(1, 1, 8'h44, 0, 0);
    run(2);
    check("t4_drops", 32'(n_drop), 32'd2);
    resp_delay = 2;
    run(40);
    check("t4_sr04_starts", 32'(n_sstart - s0), 32'd2);

    // Hung DHT transaction times out
    resp_delay = -1;
    n_tmo = 0;
    step_auto(1, 1, 8'h55, 0, 0);
    run(60);
    check("t5_timeouts", 32'(n_tmo), 32'd1);
    resp_delay = 2;
    step_auto(1, 1, 8'h55, 0, 0);
    run(40);

    // Auto-poll on, then off
    resp_delay = 4;
    d0 = n_dstart; s0 = n_sstart;
    step_auto(1, 1, 8'h41, 0, 0);
    run(650);
    check("t6_auto_dht", 32'(n_dstart - d0), 32'd3);
    check("t6_auto_sr04", 32'(n_sstart - s0), 32'd3);
    step_auto(1, 1, 8'h53, 0, 0);
    d0 = n_dstart; s0 = n_sstart;
    run(450);
    check("t6_stopped", 32'((n_dstart - d0) + (n_sstart - s0)), 32'd0);

    // Reset asserted mid-WAIT
    resp_delay = -1;
    step_auto(1, 1, 8'h55, 0, 0);
    run(5);
    check("t7_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_outputs", 32'({dht_start, sr04_start, busy, active_sensor, auto_en, req_dropped, timeout}), 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    run(20);

    // Random traffic
    resp_delay = 3;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom % 40 == 0) begin
        resp_delay = $urandom_range(0, 60);
        if (resp_delay > 55) resp_delay = -1;
      end
      r = $urandom % 10;
      b = (r < 3) ? 8'h55 : (r < 6) ? 8'h44 : (r == 6) ? 8'h41 : (r == 7) ? 8'h53 : 8'($urandom);
      step_auto(($urandom % 8) != 0, ($urandom % 6) == 0, b,
                ($urandom % 40) == 0, ($urandom % 40) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
